// File: rtl/yuv422_to_rgb.sv
// rtl/yuv422_to_rgb.sv - YUV422 word unpacker to two RGB888 pixels, two-stage pipeline
//
// Ports:
//   CLK      sole clock, rising edge
//   RESET    asynchronous active-high reset
//   S_DATA   packed word {Y1,U1,Y2,V2}
//   S_VALID  S_DATA valid
//   S_READY  word can be accepted this cycle
//   S_USER   start-of-frame flag of the word
//   S_LAST   last word of the line
//   M_DATA   pixel {R,G,B}
//   M_VALID  M_DATA valid
//   M_READY  downstream accepts the pixel
//   M_USER   start-of-frame, pixel0 of an S_USER word only
//   M_LAST   end-of-line, pixel1 of an S_LAST word only
module yuv422_to_rgb #(
    parameter int DATA_WIDTH_YUV = 32,
    parameter int DATA_WIDTH_RGB = 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [DATA_WIDTH_YUV-1:0]   S_DATA,
    input  logic                        S_VALID,
    output logic                        S_READY,
    input  logic                        S_USER,
    input  logic                        S_LAST,
    output logic [3*DATA_WIDTH_RGB-1:0] M_DATA,
    output logic                        M_VALID,
    input  logic                        M_READY,
    output logic                        M_USER,
    output logic                        M_LAST
);

    typedef enum logic [1:0] {EMPTY, PIX0, PIX1} state_t;

    state_t state;

    logic [31:0] hold_data;
    logic        hold_user;
    logic        hold_last;
    logic        hold_valid;
    logic        phase;

    logic        adv;
    logic        accept;

    logic        s1_valid;
    logic        s1_user;
    logic        s1_last;
    logic [7:0]  s1_y;
    logic signed [19:0] s1_pr;
    logic signed [19:0] s1_pg;
    logic signed [19:0] s1_pb;

    logic [7:0]  y_sel;
    logic signed [19:0] d;
    logic signed [19:0] e;
    logic signed [19:0] pr_c;
    logic signed [19:0] pg_c;
    logic signed [19:0] pb_c;

    logic signed [19:0] r_w;
    logic signed [19:0] g_w;
    logic signed [19:0] b_w;

    assign hold_valid = (state != EMPTY);
    assign phase      = (state == PIX1);

    // Whole pipeline moves together whenever the output register is free.
    assign adv     = !M_VALID || M_READY;
    // Taking a new word while pixel1 leaves the hold register avoids a bubble.
    assign S_READY = !RESET && (!hold_valid || (phase && adv));
    assign accept  = S_VALID && S_READY;

    function automatic logic [7:0] clamp8(input logic signed [19:0] v);
        if (v[19])
            clamp8 = 8'd0;
        else if (v > 20'sd255)
            clamp8 = 8'd255;
        else
            clamp8 = v[7:0];
    endfunction

    // Chroma is shared by both pixels; only luma follows the phase.
    always_comb begin
        y_sel = phase ? hold_data[15:8] : hold_data[31:24];
        d     = $signed({12'd0, hold_data[23:16]}) - 20'sd128;
        e     = $signed({12'd0, hold_data[7:0]}) - 20'sd128;
        pr_c  = 20'sd359 * e;
        pg_c  = 20'sd88 * d + 20'sd183 * e;
        pb_c  = 20'sd454 * d;
    end

    // Arithmetic shift floors the scaled chroma term before clamping.
    always_comb begin
        r_w = $signed({12'd0, s1_y}) + (s1_pr >>> 8);
        g_w = $signed({12'd0, s1_y}) - (s1_pg >>> 8);
        b_w = $signed({12'd0, s1_y}) + (s1_pb >>> 8);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= EMPTY;
            hold_data <= '0;
            hold_user <= 1'b0;
            hold_last <= 1'b0;
            s1_valid  <= 1'b0;
            s1_user   <= 1'b0;
            s1_last   <= 1'b0;
            s1_y      <= '0;
            s1_pr     <= '0;
            s1_pg     <= '0;
            s1_pb     <= '0;
            M_VALID   <= 1'b0;
            M_DATA    <= '0;
            M_USER    <= 1'b0;
            M_LAST    <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= S_DATA;
                hold_user <= S_USER;
                hold_last <= S_LAST;
            end

            case (state)
                EMPTY: if (accept) state <= PIX0;
                PIX0:  if (adv) state <= PIX1;
                PIX1:  if (adv) state <= accept ? PIX0 : EMPTY;
                default: state <= EMPTY;
            endcase

            if (adv) begin
                s1_valid <= hold_valid;
                s1_user  <= hold_valid && hold_user && !phase;
                s1_last  <= hold_valid && hold_last && phase;
                s1_y     <= y_sel;
                s1_pr    <= pr_c;
                s1_pg    <= pg_c;
                s1_pb    <= pb_c;

                M_VALID  <= s1_valid;
                M_USER   <= s1_valid && s1_user;
                M_LAST   <= s1_valid && s1_last;
                M_DATA   <= s1_valid ? {clamp8(r_w), clamp8(g_w), clamp8(b_w)} : '0;
            end
        end
    end

endmodule

// File: tb/tb_yuv422_to_rgb.sv
// tb/tb_yuv422_to_rgb.sv - self-checking bench for yuv422_to_rgb
module tb_yuv422_to_rgb;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] S_DATA;
    logic        S_VALID;
    logic        S_READY;
    logic        S_USER;
    logic        S_LAST;
    logic [23:0] M_DATA;
    logic        M_VALID;
    logic        M_READY;
    logic        M_USER;
    logic        M_LAST;

    yuv422_to_rgb #(.DATA_WIDTH_YUV(32), .DATA_WIDTH_RGB(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
        .S_USER(S_USER), .S_LAST(S_LAST),
        .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
        .M_USER(M_USER), .M_LAST(M_LAST)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    int run = 0;
    int max_run = 0;
    bit accepted;
    logic [25:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] sat(input int x);
        logic [31:0] t;
        t = x;
        if (x < 0) return 8'd0;
        if (x > 255) return 8'd255;
        return t[7:0];
    endfunction

    // Colour equations on plain integers; >>> on a signed int is a floor divide by 256.
    function automatic logic [23:0] ref_pix(input int y, input int u, input int v);
        int dd, ee;
        dd = u - 128;
        ee = v - 128;
        return {sat(y + ((359 * ee) >>> 8)),
                sat(y - ((88 * dd + 183 * ee) >>> 8)),
                sat(y + ((454 * dd) >>> 8))};
    endfunction

    // One clock: observe handshakes at the negedge, return just after the posedge.
    task automatic tick();
        logic [25:0] ex;
        int y1, u1, y2, v2;
        @(negedge CLK);
        if (M_VALID && M_READY) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pixel", exp_q.size(), 1);
            end else begin
                ex = exp_q.pop_front();
                chk("pixel", {6'd0, M_USER, M_LAST, M_DATA}, {6'd0, ex});
                n_out++;
            end
        end
        if (M_VALID) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        accepted = !RESET && S_VALID && S_READY;
        if (accepted) begin
            y1 = int'(S_DATA[31:24]);
            u1 = int'(S_DATA[23:16]);
            y2 = int'(S_DATA[15:8]);
            v2 = int'(S_DATA[7:0]);
            exp_q.push_back({S_USER, 1'b0, ref_pix(y1, u1, v2)});
            exp_q.push_back({1'b0, S_LAST, ref_pix(y2, u1, v2)});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [31:0] data, input logic user, input logic last,
                             output int waits);
        S_DATA  = data;
        S_USER  = user;
        S_LAST  = last;
        S_VALID = 1'b1;
        waits   = 0;
        do begin
            tick();
            waits++;
        end while (!accepted && waits < 20);
        chk("send_accepted", {31'd0, accepted}, 1);
    endtask

    task automatic drain();
        int n;
        S_VALID = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || M_VALID) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Single word on an idle pipeline with fixed expected pixels and latency.
    task automatic dir_word(input string tag, input logic [31:0] data, input logic user,
                            input logic last, input logic [23:0] p0, input logic [23:0] p1);
        int w;
        send_word(data, user, last, w);
        S_VALID = 1'b0;
        chk({tag, "_lat0"}, {31'd0, M_VALID}, 0);
        tick();
        chk({tag, "_lat1"}, {31'd0, M_VALID}, 0);
        tick();
        chk({tag, "_p0_valid"}, {31'd0, M_VALID}, 1);
        chk({tag, "_p0_data"}, {8'd0, M_DATA}, {8'd0, p0});
        chk({tag, "_p0_flags"}, {30'd0, M_USER, M_LAST}, {30'd0, user, 1'b0});
        tick();
        chk({tag, "_p1_valid"}, {31'd0, M_VALID}, 1);
        chk({tag, "_p1_data"}, {8'd0, M_DATA}, {8'd0, p1});
        chk({tag, "_p1_flags"}, {30'd0, M_USER, M_LAST}, {30'd0, 1'b0, last});
        tick();
        chk({tag, "_after"}, {31'd0, M_VALID}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int out0;
        logic [23:0] snap;

        RESET   = 1'b1;
        S_DATA  = '0;
        S_VALID = 1'b0;
        S_USER  = 1'b0;
        S_LAST  = 1'b0;
        M_READY = 1'b1;

        // Reset defaults
        repeat (3) begin
            tick();
            chk("rst_sready", {31'd0, S_READY}, 0);
            chk("rst_mvalid", {31'd0, M_VALID}, 0);
            chk("rst_mdata", {8'd0, M_DATA}, 0);
        end
        RESET = 1'b0;
        #1;
        chk("post_rst_sready", {31'd0, S_READY}, 1);
        chk("post_rst_mvalid", {31'd0, M_VALID}, 0);
        tick();

        // Directed words
        dir_word("grey", 32'h8080_8080, 1'b0, 1'b0, 24'h808080, 24'h808080);
        dir_word("clamp_hi", 32'hFF80_FFFF, 1'b0, 1'b0, 24'hFFA5FF, 24'hFFA5FF);
        dir_word("clamp_lo", 32'h0080_0000, 1'b0, 1'b0, 24'h005C00, 24'h005C00);
        dir_word("luma", 32'h1080_6480, 1'b1, 1'b1, 24'h101010, 24'h646464);
        drain();

        // Continuous stream of random words
        out0 = n_out;
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            send_word($urandom, (i == 0), (i == 7), w);
            if (i == 0) chk("stream_first_wait", w, 1);
            else        chk("stream_ready_toggle", w, 2);
        end
        drain();
        chk("stream_run", max_run, 16);
        chk("stream_count", n_out - out0, 16);

        // Backpressure mid-stream
        out0 = n_out;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                M_READY = 1'b0;
                snap = M_DATA;
                chk("bp_valid_start", {31'd0, M_VALID}, 1);
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk("bp_mdata_stable", {8'd0, M_DATA}, {8'd0, snap});
                    chk("bp_sready", {31'd0, S_READY}, 0);
                    chk("bp_mvalid", {31'd0, M_VALID}, 1);
                end
                M_READY = 1'b1;
            end
            send_word($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
        drain();
        chk("bp_count", n_out - out0, 16);

        // Reset in the middle of a word
        send_word($urandom, 1'b1, 1'b1, w);
        S_VALID = 1'b0;
        tick();
        tick();
        chk("mid_rst_pre_valid", {31'd0, M_VALID}, 1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_async_mvalid", {31'd0, M_VALID}, 0);
        chk("mid_rst_sready", {31'd0, S_READY}, 0);
        chk("mid_rst_mdata", {8'd0, M_DATA}, 0);
        exp_q.delete();
        tick();
        tick();
        RESET = 1'b0;
        repeat (3) begin
            tick();
            chk("post_mid_rst_idle", {31'd0, M_VALID}, 0);
        end
        dir_word("after_rst", 32'h1080_6480, 1'b1, 1'b1, 24'h101010, 24'h646464);
        drain();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
